// File: rtl/wb_arbiter.sv
// wb_arbiter
// Writeback stage of the RV32 core and the only driver of the register
// file write port. Two producers, the ALU and the load unit, offer results
// over valid/ready channels. Loads normally win. An ALU anti-starvation
// counter forces an ALU grant after MAX_WAIT consecutive lost cycles. The
// winner is registered into a one-deep output stage. Two bypass taps
// forward the in-flight write to the read ports.
//
// Ports
//   CLK, RST               clock; synchronous active-high reset
//   alu_valid/rd/data      ALU result channel;  alu_ready = accepted this cycle
//   ld_valid/rd/data       load result channel; ld_ready  = accepted this cycle
//   WRITE, wb_addr, wb_data  register file write port (one cycle after grant)
//   byp_addr_a/b           read port addresses to compare against the write
//   byp_hit_a/b, byp_data_a/b  forwarded write data (0 when no hit)
//   retired_cnt            number of register writes performed (wraps)

module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,

    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,

    output logic            WRITE,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,

    input  logic [4:0]      byp_addr_a,
    output logic            byp_hit_a,
    output logic [XLEN-1:0] byp_data_a,
    input  logic [4:0]      byp_addr_b,
    output logic            byp_hit_b,
    output logic [XLEN-1:0] byp_data_b,

    output logic [31:0]     retired_cnt
);

    localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

    logic [3:0]      wait_cnt;
    logic            force_alu;
    logic            grant_alu;
    logic            grant_ld;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign force_alu = (wait_cnt == MAX_WAIT_W);

    // Grant is gated by RST so nothing is accepted while reset is applied.
    // The register file takes a write every cycle, so the grant never has
    // to look at the output stage.
    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        sel_rd    = ld_rd;
        sel_data  = ld_data;
        if (!RST) begin
            if (alu_valid && ld_valid) begin
                grant_alu = force_alu;
                grant_ld  = !force_alu;
            end else begin
                grant_alu = alu_valid;
                grant_ld  = ld_valid;
            end
        end
        if (grant_alu) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;

    // Counts consecutive cycles in which the ALU offered a result and lost.
    // The count saturates at MAX_WAIT, which is the value that forces the
    // ALU grant above.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= 4'd0;
        end else if (alu_valid && !grant_alu) begin
            if (wait_cnt != MAX_WAIT_W) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Writes to x0 are accepted and then dropped by leaving WRITE low.
    // When there is no grant, the address and data hold their values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WRITE   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= '0;
        end else if (grant_alu || grant_ld) begin
            WRITE   <= (sel_rd != 5'd0);
            wb_addr <= sel_rd;
            wb_data <= sel_data;
        end else begin
            WRITE   <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_cnt <= 32'd0;
        end else if (WRITE) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    // wb_addr is never 0 while WRITE is high, but the explicit x0 test
    // keeps the taps safe regardless of what the output stage holds.
    assign byp_hit_a  = WRITE && (byp_addr_a == wb_addr) && (byp_addr_a != 5'd0);
    assign byp_hit_b  = WRITE && (byp_addr_b == wb_addr) && (byp_addr_b != 5'd0);
    assign byp_data_a = byp_hit_a ? wb_data : '0;
    assign byp_data_b = byp_hit_b ? wb_data : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. It runs the directed scenarios first:
// reset, a single ALU write, ALU starvation, the x0 drop, bypass, and a
// reset in the middle of a write. It then runs randomized producer traffic.
// Every cycle the DUT is compared against a behavioural model of the
// writeback rules.

module tb_wb_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 3;

    logic            CLK = 1'b0;
    logic            RST;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            WRITE;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      byp_addr_a;
    logic            byp_hit_a;
    logic [XLEN-1:0] byp_data_a;
    logic [4:0]      byp_addr_b;
    logic            byp_hit_b;
    logic [XLEN-1:0] byp_data_b;
    logic [31:0]     retired_cnt;

    wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .WRITE       (WRITE),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .byp_addr_a  (byp_addr_a),
        .byp_hit_a   (byp_hit_a),
        .byp_data_a  (byp_data_a),
        .byp_addr_b  (byp_addr_b),
        .byp_hit_b   (byp_hit_b),
        .byp_data_b  (byp_data_b),
        .retired_cnt (retired_cnt)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the write port as the register file should see it
    logic        mWrite   = 1'b0;
    logic [4:0]  mAddr    = 5'd0;
    logic [31:0] mData    = 32'd0;
    logic [31:0] mRetired = 32'd0;
    int          aluLosses = 0;

    // Grants of the most recent cycle: model view and DUT view
    logic gotAlu, gotLd;
    logic dutAlu, dutLd;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Runs one clock cycle, starting and ending at a negedge. Inputs are
    // driven first, then the combinational outputs are checked. The model
    // is advanced at the posedge, and the registered outputs are checked at
    // the next negedge.
    task automatic applyStimulus(input logic rst,
                                 input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic [4:0] ba, input logic [4:0] bb);
        logic expA, expL, hitA, hitB;
        RST        = rst;
        alu_valid  = av;
        alu_rd     = ard;
        alu_data   = adat;
        ld_valid   = lv;
        ld_rd      = lrd;
        ld_data    = ldat;
        byp_addr_a = ba;
        byp_addr_b = bb;
        #1;
        expA = 1'b0;
        expL = 1'b0;
        if (!rst) begin
            if (av && lv) begin
                if (aluLosses == MAX_WAIT) expA = 1'b1;
                else                       expL = 1'b1;
            end else begin
                expA = av;
                expL = lv;
            end
        end
        hitA = mWrite && (ba == mAddr) && (ba != 5'd0);
        hitB = mWrite && (bb == mAddr) && (bb != 5'd0);
        checkOutput("alu_ready",  32'(alu_ready),  32'(expA));
        checkOutput("ld_ready",   32'(ld_ready),   32'(expL));
        checkOutput("byp_hit_a",  32'(byp_hit_a),  32'(hitA));
        checkOutput("byp_hit_b",  32'(byp_hit_b),  32'(hitB));
        checkOutput("byp_data_a", byp_data_a, hitA ? mData : 32'd0);
        checkOutput("byp_data_b", byp_data_b, hitB ? mData : 32'd0);
        gotAlu = expA;
        gotLd  = expL;
        dutAlu = alu_ready;
        dutLd  = ld_ready;
        @(posedge CLK);
        if (rst) begin
            mWrite    = 1'b0;
            mAddr     = 5'd0;
            mData     = 32'd0;
            mRetired  = 32'd0;
            aluLosses = 0;
        end else begin
            if (mWrite) mRetired = mRetired + 32'd1;
            if (expA) begin
                mWrite = (ard != 5'd0);
                mAddr  = ard;
                mData  = adat;
            end else if (expL) begin
                mWrite = (lrd != 5'd0);
                mAddr  = lrd;
                mData  = ldat;
            end else begin
                mWrite = 1'b0;
            end
            if (av && !expA) aluLosses = (aluLosses < MAX_WAIT) ? aluLosses + 1 : MAX_WAIT;
            else             aluLosses = 0;
        end
        @(negedge CLK);
        checkOutput("WRITE",       32'(WRITE),   32'(mWrite));
        checkOutput("wb_addr",     32'(wb_addr), 32'(mAddr));
        checkOutput("wb_data",     wb_data,      mData);
        checkOutput("retired_cnt", retired_cnt,  mRetired);
    endtask

    task automatic idleCycle(input logic [4:0] ba, input logic [4:0] bb);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ba, bb);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic        aluPend, ldPend;
        logic [4:0]  aRd, lRd;
        logic [31:0] aDat, lDat;

        RST = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = '0;
        byp_addr_a = 5'd0; byp_addr_b = 5'd0;
        @(negedge CLK);

        $display("[TB] reset with both producers valid");
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'b1, 5'd4, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd4, 5'd6);

        $display("[TB] single ALU write");
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkOutput("single_write", 32'(WRITE), 32'd1);
        idleCycle(5'd0, 5'd0);
        checkOutput("single_retired", retired_cnt, 32'd1);

        $display("[TB] ALU starvation");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        aRd = 5'd20;
        lRd = 5'd1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, aRd, 32'hA000_0000 + 32'(aRd),
                          1'b1, lRd, 32'hB000_0000 + 32'(lRd), 5'd0, 5'd0);
            checkOutput("starve_alu_grant", 32'(dutAlu), (i % 4 == 3) ? 32'd1 : 32'd0);
            if (gotAlu) aRd = aRd + 5'd1;
            if (gotLd)  lRd = lRd + 5'd1;
        end
        idleCycle(5'd0, 5'd0);
        checkOutput("starve_retired", retired_cnt, 32'd8);

        $display("[TB] x0 drop");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        checkOutput("x0_ld_ready", 32'(dutLd), 32'd1);
        checkOutput("x0_write", 32'(WRITE), 32'd0);
        idleCycle(5'd0, 5'd0);
        checkOutput("x0_retired", retired_cnt, 32'd8);

        $display("[TB] bypass");
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idleCycle(5'd7, 5'd7);
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idleCycle(5'd7, 5'd8);

        $display("[TB] reset during a write");
        applyStimulus(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 5'd3, 5'd0);
        checkOutput("midrst_write", 32'(WRITE), 32'd0);
        checkOutput("midrst_retired", retired_cnt, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd0);
        checkOutput("postrst_ld_ready", 32'(dutLd), 32'd1);

        $display("[TB] randomized traffic");
        aluPend = 1'b0;
        ldPend  = 1'b0;
        aDat = 32'd0;
        lDat = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [4:0] ba, bb;
            if (!aluPend && ($urandom_range(2, 0) != 0)) begin
                aluPend = 1'b1;
                aRd     = 5'($urandom_range(31, 0));
                aDat    = $urandom;
            end
            if (!ldPend && ($urandom_range(2, 0) != 0)) begin
                ldPend = 1'b1;
                lRd    = 5'($urandom_range(31, 0));
                lDat   = $urandom;
            end
            r  = ($urandom_range(39, 0) == 0);
            ba = ($urandom_range(1, 0) == 1) ? mAddr : 5'($urandom_range(31, 0));
            bb = ($urandom_range(1, 0) == 1) ? mAddr : 5'($urandom_range(31, 0));
            applyStimulus(r, aluPend, aRd, aDat, ldPend, lRd, lDat, ba, bb);
            if (gotAlu) aluPend = 1'b0;
            if (gotLd)  ldPend  = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage for the RV32 core and the sole driver of the register file's write port (WRITE, write address, write data). Accepts results from two producers, the ALU and the load unit, over valid/ready channels. Arbitrates between them with load priority and an ALU anti-starvation counter. Registers the winner into a one-deep output stage and provides bypass taps, so reads issued while a write is in flight get the new value.

Parameters:
XLEN, 32, data width of results and write data
MAX_WAIT, 3, consecutive cycles the ALU may lose arbitration before it is forced to win (1..15)

Ports:
CLK  input  1  clock, all state updates on posedge
RST  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result available
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
alu_ready  output  1  ALU result accepted this cycle
ld_valid  input  1  load result available
ld_rd  input  5  load destination register
ld_data  input  XLEN  load result
ld_ready  output  1  load result accepted this cycle
WRITE  output  1  register file write enable
wb_addr  output  5  register file write address
wb_data  output  XLEN  register file write data
byp_addr_a  input  5  read port A address (tap)
byp_hit_a  output  1  in-flight write matches port A
byp_data_a  output  XLEN  forwarded data for port A
byp_addr_b  input  5  read port B address (tap)
byp_hit_b  output  1  in-flight write matches port B
byp_data_b  output  XLEN  forwarded data for port B
retired_cnt  output  32  count of register writes performed

Behaviour:
- Reset (RST high at posedge):
  - WRITE=0, wb_addr=0, wb_data=0, retired_cnt=0, wait_cnt=0.
  - alu_ready and ld_ready are forced to 0 combinationally while RST is high.
  - Any result presented during reset is not accepted.
- Grant rule (combinational, RST low):
  - only ld_valid: grant load.
  - only alu_valid: grant ALU.
  - both valid: grant load, unless wait_cnt==MAX_WAIT, in which case grant ALU.
  - neither valid: no grant.
  - ready outputs equal their grant. At most one grant per cycle.
  - Ready never depends on the output stage; the register file absorbs one write every cycle.
- wait_cnt (4 bits):
  - on posedge, if alu_valid and the ALU is not granted: increment, saturating at MAX_WAIT.
  - otherwise (ALU granted, or alu_valid low): clear to 0.
- Output stage (posedge, latency 1):
  - on a grant: wb_addr<=rd, wb_data<=data, WRITE<=(rd!=0).
  - with no grant: WRITE<=0; wb_addr and wb_data hold their values.
  - rd==0 results are accepted (ready=1) and silently dropped. WRITE stays 0.
- retired_cnt:
  - increments by 1 on each posedge where WRITE==1. Wraps modulo 2^32.
- Bypass (combinational):
  - byp_hit_x = WRITE && (byp_addr_x==wb_addr) && (byp_addr_x!=0).
  - byp_data_x = wb_data when hit, else 0. Ports A and B are independent and may hit simultaneously.
- Producer rules:
  - A producer holds valid/rd/data stable until ready.
  - A producer may withdraw only after acceptance. The block assumes nothing else.
- Reset mid-operation: the output-stage write in progress is cancelled (WRITE=0 next cycle) and counters clear. There is no partial-state carry-over.

Test Plan:
- Reset: hold RST 2 cycles with alu_valid=ld_valid=1 -> alu_ready=ld_ready=0 throughout; WRITE=0, wb_addr=0, wb_data=0, retired_cnt=0.
- Single ALU write: cycle N alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 in N; cycle N+1 WRITE=1, wb_addr=5, wb_data=0xDEADBEEF; cycle N+2 WRITE=0, retired_cnt=1.
- Starvation (MAX_WAIT=3): both valid every cycle, distinct rd each beat -> grant sequence L,L,L,A,L,L,L,A; wait_cnt returns to 0 after each ALU grant; retired_cnt=8 after 8 grants.
- x0 drop: ld_valid=1, ld_rd=0, ld_data=0xFFFFFFFF -> ld_ready=1; WRITE stays 0 next cycle; retired_cnt unchanged; byp_hit_a=0 with byp_addr_a=0.
- Bypass: ALU writes x7=0x12345678; in the WRITE cycle byp_addr_a=7, byp_addr_b=7 -> both hits=1, data=0x12345678; byp_addr_b=8 -> byp_hit_b=0, byp_data_b=0.
- Mid-op reset: RST asserted in the cycle WRITE=1 (x3=0xA5A5A5A5) -> next cycle WRITE=0, retired_cnt=0, wait_cnt=0; after RST drops, a pending ld_valid is granted on the first cycle.
